// File: rtl/sdram_resp_pkg.sv
// Shared types and helpers for the SDRAM responder: command encoding,
// mode-register field layout, burst/CAS decode and bank state.
package sdram_resp_pkg;

   // Command encoding is exactly {ras_n, cas_n, we_n} while cs_n is low.
   typedef enum logic [2:0] {
      CMD_LOAD_MODE  = 3'b000,
      CMD_REFRESH    = 3'b001,
      CMD_PRECHARGE  = 3'b010,
      CMD_ACTIVE     = 3'b011,
      CMD_WRITE      = 3'b100,
      CMD_READ       = 3'b101,
      CMD_BURST_TERM = 3'b110,
      CMD_NOP        = 3'b111
   } cmd_e;

   typedef enum logic {
      BANK_IDLE   = 1'b0,
      BANK_ACTIVE = 1'b1
   } bank_state_e;

   // Mode-register field offsets within dram_addr.
   localparam int MR_BL_LSB  = 0;
   localparam int MR_CL_LSB  = 4;
   localparam int MR_FIELD_W = 3;
   localparam int MR_WB_BIT  = 9;
   // PRECHARGE all-banks select bit.
   localparam int AP_BIT     = 10;

   // Burst-length codes 0..3 map to 1,2,4,8 beats.
   function automatic logic [3:0] bl_decode(input logic [1:0] code);
      return 4'd1 << code;
   endfunction

   function automatic logic bl_code_ok(input logic [2:0] code);
      return code[2] == 1'b0;
   endfunction

   // Only CAS latencies 2 and 3 are supported.
   function automatic logic cl_ok(input logic [2:0] code);
      return code[2:1] == 2'b01;
   endfunction

endpackage

// File: rtl/sdram_resp_rdpipe.sv
// Read-data delay line: the store register provides the first latency stage,
// an optional stage stretches CL2 to CL3, and the output register applies the
// byte-lane mask captured one edge earlier (two-cycle DQM read latency).
module sdram_resp_rdpipe
   import sdram_resp_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DQM_WIDTH  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cke_i,
   input  logic                  cl3_i,
   input  logic                  vld_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic [DQM_WIDTH-1:0]  dqm_i,
   output logic [DATA_WIDTH-1:0] dq_out_o,
   output logic [DQM_WIDTH-1:0]  dq_oe_o
);

   logic                  dly_vld_q;
   logic [DATA_WIDTH-1:0] dly_data_q;
   logic [DQM_WIDTH-1:0]  dqm_q;
   logic [DATA_WIDTH-1:0] dq_out_q, dq_out_d;
   logic [DQM_WIDTH-1:0]  dq_oe_q, dq_oe_d;
   logic                  beat_vld;
   logic [DATA_WIDTH-1:0] beat_data;

   // Select the beat at the depth matching the programmed CAS latency, then mask lanes.
   always_comb begin
      beat_vld  = cl3_i ? dly_vld_q  : vld_i;
      beat_data = cl3_i ? dly_data_q : data_i;
      dq_oe_d   = '0;
      dq_out_d  = '0;
      for (int l = 0; l < DQM_WIDTH; l++) begin
         dq_oe_d[l]         = beat_vld & ~dqm_q[l];
         dq_out_d[l*8 +: 8] = dq_oe_d[l] ? beat_data[l*8 +: 8] : 8'h00;
      end
   end

   // Pipeline registers; everything freezes while CKE is low.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dly_vld_q  <= 1'b0;
         dly_data_q <= '0;
         dqm_q      <= '0;
         dq_out_q   <= '0;
         dq_oe_q    <= '0;
      end else if (cke_i) begin
         dly_vld_q  <= vld_i;
         dly_data_q <= data_i;
         dqm_q      <= dqm_i;
         dq_out_q   <= dq_out_d;
         dq_oe_q    <= dq_oe_d;
      end
   end

   assign dq_out_o = dq_out_q;
   assign dq_oe_o  = dq_oe_q;

endmodule

// File: rtl/sdram_responder.sv
// Device-side SDRAM responder: command decoder, per-bank row table, mode
// register, burst engine and a byte-lane backing store feeding the read pipe.
module sdram_responder
   import sdram_resp_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DQM_WIDTH  = 4,
   parameter int ADDR_WIDTH = 12,
   parameter int BA_WIDTH   = 2,
   parameter int COL_WIDTH  = 8,
   parameter int MEM_AW     = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  dram_cke,
   input  logic                  dram_cs_n,
   input  logic                  dram_ras_n,
   input  logic                  dram_cas_n,
   input  logic                  dram_we_n,
   input  logic [BA_WIDTH-1:0]   dram_ba,
   input  logic [ADDR_WIDTH-1:0] dram_addr,
   input  logic [DQM_WIDTH-1:0]  dram_dqm,
   input  logic [DATA_WIDTH-1:0] dram_dq_in,
   output logic [DATA_WIDTH-1:0] dram_dq_out,
   output logic [DQM_WIDTH-1:0]  dram_dq_oe,
   output logic                  cmd_err
);

   localparam int NUM_BANKS = 1 << BA_WIDTH;
   localparam int FULL_AW   = BA_WIDTH + ADDR_WIDTH + COL_WIDTH;

   cmd_e                  cmd;
   bank_state_e           bank_st_q [NUM_BANKS];
   bank_state_e           bank_st_d [NUM_BANKS];
   logic [ADDR_WIDTH-1:0] row_q     [NUM_BANKS];
   logic [ADDR_WIDTH-1:0] row_d     [NUM_BANKS];
   logic                  mode_valid_q, mode_valid_d;
   logic [1:0]            bl_code_q, bl_code_d;
   logic                  cl3_q, cl3_d;
   logic                  single_wr_q, single_wr_d;
   logic                  cmd_err_q, cmd_err_d;
   logic                  burst_act_q, burst_act_d;
   logic                  burst_rd_q, burst_rd_d;
   logic [FULL_AW-1:0]    burst_base_q, burst_base_d;
   logic [3:0]            burst_len_q, burst_len_d;
   logic [2:0]            burst_cnt_q, burst_cnt_d;
   logic                  any_active, kill_burst, start_burst;
   logic [3:0]            start_len;
   logic [FULL_AW-1:0]    start_full;
   logic [COL_WIDTH-1:0]  base_col, wrap_mask, col_sum, wrap_col;
   logic                  beat_en, beat_rd;
   logic [MEM_AW-1:0]     beat_addr;
   logic                  rd_valid_q;
   logic [DATA_WIDTH-1:0] rd_data;

   // Deselected chip behaves as NOP; otherwise the pins are the command code.
   always_comb begin
      cmd = dram_cs_n ? CMD_NOP : cmd_e'({dram_ras_n, dram_cas_n, dram_we_n});
      any_active = 1'b0;
      for (int b = 0; b < NUM_BANKS; b++)
         if (bank_st_q[b] == BANK_ACTIVE) any_active = 1'b1;
   end

   // Sequential column wrap: low log2(BL) bits advance modulo BL, upper bits fixed.
   always_comb begin
      base_col  = burst_base_q[COL_WIDTH-1:0];
      wrap_mask = COL_WIDTH'(burst_len_q - 4'd1);
      col_sum   = base_col + COL_WIDTH'(burst_cnt_q);
      wrap_col  = (base_col & ~wrap_mask) | (col_sum & wrap_mask);
   end

   // Command decode, bank/mode updates and burst sequencing.
   always_comb begin
      bank_st_d    = bank_st_q;
      row_d        = row_q;
      mode_valid_d = mode_valid_q;
      bl_code_d    = bl_code_q;
      cl3_d        = cl3_q;
      single_wr_d  = single_wr_q;
      burst_act_d  = burst_act_q;
      burst_rd_d   = burst_rd_q;
      burst_base_d = burst_base_q;
      burst_len_d  = burst_len_q;
      burst_cnt_d  = burst_cnt_q;
      cmd_err_d    = 1'b0;
      kill_burst   = 1'b0;
      start_burst  = 1'b0;
      start_len    = 4'd1;
      start_full   = {dram_ba, row_q[dram_ba], dram_addr[COL_WIDTH-1:0]};
      beat_en      = 1'b0;
      beat_rd      = 1'b0;
      beat_addr    = '0;
      case (cmd)
         CMD_ACTIVE: begin
            if (bank_st_q[dram_ba] == BANK_ACTIVE) begin
               cmd_err_d = 1'b1;
            end else begin
               bank_st_d[dram_ba] = BANK_ACTIVE;
               row_d[dram_ba]     = dram_addr;
            end
         end
         CMD_PRECHARGE: begin
            if (dram_addr[AP_BIT]) begin
               for (int b = 0; b < NUM_BANKS; b++) bank_st_d[b] = BANK_IDLE;
               kill_burst = 1'b1;
            end else begin
               bank_st_d[dram_ba] = BANK_IDLE;
               kill_burst = (burst_base_q[FULL_AW-1 -: BA_WIDTH] == dram_ba);
            end
         end
         CMD_REFRESH: cmd_err_d = any_active;
         CMD_LOAD_MODE: begin
            if (any_active || !bl_code_ok(dram_addr[MR_BL_LSB +: MR_FIELD_W]) ||
                !cl_ok(dram_addr[MR_CL_LSB +: MR_FIELD_W])) begin
               cmd_err_d = 1'b1;
            end else begin
               mode_valid_d = 1'b1;
               bl_code_d    = dram_addr[MR_BL_LSB +: 2];
               cl3_d        = (dram_addr[MR_CL_LSB +: MR_FIELD_W] == 3'd3);
               single_wr_d  = dram_addr[MR_WB_BIT];
            end
         end
         CMD_READ, CMD_WRITE: begin
            if (!mode_valid_q || bank_st_q[dram_ba] != BANK_ACTIVE) cmd_err_d = 1'b1;
            else start_burst = 1'b1;
         end
         CMD_BURST_TERM: kill_burst = 1'b1;
         default: ;
      endcase
      if (start_burst) begin
         // Beat 0 of a new burst goes out on the command edge itself.
         start_len    = (cmd == CMD_WRITE && single_wr_q) ? 4'd1 : bl_decode(bl_code_q);
         beat_en      = 1'b1;
         beat_rd      = (cmd == CMD_READ);
         beat_addr    = MEM_AW'(start_full);
         burst_act_d  = (start_len != 4'd1);
         burst_rd_d   = beat_rd;
         burst_base_d = start_full;
         burst_len_d  = start_len;
         burst_cnt_d  = 3'd1;
      end else if (kill_burst) begin
         burst_act_d = 1'b0;
      end else if (burst_act_q) begin
         beat_en     = 1'b1;
         beat_rd     = burst_rd_q;
         beat_addr   = MEM_AW'({burst_base_q[FULL_AW-1:COL_WIDTH], wrap_col});
         burst_cnt_d = burst_cnt_q + 3'd1;
         if (4'(burst_cnt_q) + 4'd1 == burst_len_q) burst_act_d = 1'b0;
      end
   end

   // Control state registers; CKE low holds everything.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int b = 0; b < NUM_BANKS; b++) begin
            bank_st_q[b] <= BANK_IDLE;
            row_q[b]     <= '0;
         end
         mode_valid_q <= 1'b0;
         bl_code_q    <= 2'd0;
         cl3_q        <= 1'b1;
         single_wr_q  <= 1'b0;
         cmd_err_q    <= 1'b0;
         burst_act_q  <= 1'b0;
         burst_rd_q   <= 1'b0;
         burst_base_q <= '0;
         burst_len_q  <= 4'd1;
         burst_cnt_q  <= 3'd0;
         rd_valid_q   <= 1'b0;
      end else if (dram_cke) begin
         bank_st_q    <= bank_st_d;
         row_q        <= row_d;
         mode_valid_q <= mode_valid_d;
         bl_code_q    <= bl_code_d;
         cl3_q        <= cl3_d;
         single_wr_q  <= single_wr_d;
         cmd_err_q    <= cmd_err_d;
         burst_act_q  <= burst_act_d;
         burst_rd_q   <= burst_rd_d;
         burst_base_q <= burst_base_d;
         burst_len_q  <= burst_len_d;
         burst_cnt_q  <= burst_cnt_d;
         rd_valid_q   <= beat_en & beat_rd;
      end
   end

   // One RAM per byte lane so masked lanes simply skip their write enable.
   for (genvar gi = 0; gi < DQM_WIDTH; gi++) begin : g_lane
      logic [7:0] mem [2**MEM_AW];
      logic [7:0] rd_byte_q;

      // Registered read / byte-masked write of the store.
      always_ff @(posedge clk) begin
         if (dram_cke && beat_en) begin
            if (beat_rd) rd_byte_q <= mem[beat_addr];
            else if (!dram_dqm[gi]) mem[beat_addr] <= dram_dq_in[gi*8 +: 8];
         end
      end

      assign rd_data[gi*8 +: 8] = rd_byte_q;
   end

   sdram_resp_rdpipe #(
      .DATA_WIDTH (DATA_WIDTH),
      .DQM_WIDTH  (DQM_WIDTH)
   ) u_rdpipe (
      .clk      (clk),
      .rst      (rst),
      .cke_i    (dram_cke),
      .cl3_i    (cl3_q),
      .vld_i    (rd_valid_q),
      .data_i   (rd_data),
      .dqm_i    (dram_dqm),
      .dq_out_o (dram_dq_out),
      .dq_oe_o  (dram_dq_oe)
   );

   assign cmd_err = cmd_err_q;

endmodule
